// File: rtl/cosim_lockstep_checker_if.sv
// Bus between the lockstep checker and the two DUT instances plus status
// consumer. master = checker side, slave = environment side.
interface cosim_lockstep_checker_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1,
  parameter int CNT_W = 16
);
  logic                   start;
  logic                   dut_rst;
  logic [LANES*WIDTH-1:0] stim;
  logic [LANES*WIDTH-1:0] gold_out;
  logic [LANES*WIDTH-1:0] net_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [CNT_W-1:0]       mismatch_cnt;
  logic [CNT_W-1:0]       vec_cnt;
  logic [5:0]             first_fail_lane;
  logic [CNT_W-1:0]       first_fail_vec;
  logic [WIDTH-1:0]       first_gold;
  logic [WIDTH-1:0]       first_net;

  modport master (
    input  start, gold_out, net_out,
    output dut_rst, stim, busy, done, pass, mismatch_cnt, vec_cnt,
           first_fail_lane, first_fail_vec, first_gold, first_net
  );

  modport slave (
    output start, gold_out, net_out,
    input  dut_rst, stim, busy, done, pass, mismatch_cnt, vec_cnt,
           first_fail_lane, first_fail_vec, first_gold, first_net
  );
endinterface

// File: rtl/cosim_lockstep_checker.sv
// Lockstep checker: drives shared stimulus/reset into golden and netlist
// DUTs over LANES channels, compares after a settle window, counts
// mismatches and captures the first failure.

// Per-lane LFSR and compare.
module cosim_lockstep_lane #(
  parameter int          WIDTH  = 32,
  parameter logic [31:0] SEED_K = 32'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] net,
  output logic             fail,
  output logic [31:0]      cur,
  output logic [31:0]      nxt
);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  // right-shifting Galois step
  assign nxt  = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
  assign fail = (gold != net);

  // LFSR state: reloaded on run start, stepped once per random vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cur <= SEED_K;
    else if (load) cur <= SEED_K;
    else if (adv)  cur <= nxt;
  end
endmodule

module cosim_lockstep_checker #(
  parameter int          WIDTH       = 32,
  parameter int          LANES       = 1,
  parameter int          NUM_VECTORS = 1000,
  parameter int          SETTLE      = 2,
  parameter logic [31:0] SEED        = 32'h0000_0001,
  parameter logic [31:0] DIRECTED    = 32'habcdefab,
  parameter int          CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst,
  cosim_lockstep_checker_if.master bus
);
  localparam int CYC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW    = CNT_W + 8;

  typedef enum logic [2:0] {IDLE, RST1, GAP1, RUN, RST2, GAP2, DIR, DONE} state_t;

  // replicate a 32-bit pattern across WIDTH, truncating the tail
  function automatic logic [WIDTH-1:0] rep32(input logic [31:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[i % 32];
    return r;
  endfunction

  state_t                        state;
  logic [CYC_W-1:0]              cyc;
  logic [31:0]                   vec_idx;
  logic                          start_q;
  logic                          go, last, cmp, adv;
  logic [LANES-1:0]              fail;
  logic [LANES-1:0][31:0]        lfsr_cur, lfsr_nxt;
  logic [LANES-1:0][WIDTH-1:0]   gold_v, net_v, stim_q;
  logic [LANES-1:0][WIDTH-1:0]   rnd_cur, rnd_nxt, dir_v;
  logic [6:0]                    fail_n;
  logic [5:0]                    low_lane;
  logic                          any_fail;
  logic [WIDTH-1:0]              low_gold, low_net;
  logic [SW-1:0]                 mm_sum;
  logic [CNT_W-1:0]              mm_nxt;
  logic                          busy_q, done_q, pass_q, dut_rst_q;
  logic [CNT_W-1:0]              mm_q, vc_q, ffv_q;
  logic [5:0]                    ffl_q;
  logic [WIDTH-1:0]              fg_q, fn_q;

  assign gold_v = bus.gold_out;
  assign net_v  = bus.net_out;

  // start is edge-qualified so a start held through a run does not re-launch it
  assign go   = bus.start && !start_q && (state == IDLE || state == DONE);
  assign last = (cyc == CYC_W'(SETTLE - 1));
  assign cmp  = last && (state == RST1 || state == RUN || state == RST2 || state == DIR);
  assign adv  = last && (state == RUN);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [31:0] SUM = SEED + 32'(k);
    localparam logic [31:0] SK  = (SUM == 32'h0) ? 32'h1 : SUM;
    cosim_lockstep_lane #(.WIDTH(WIDTH), .SEED_K(SK)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (go),
      .adv  (adv),
      .gold (gold_v[k]),
      .net  (net_v[k]),
      .fail (fail[k]),
      .cur  (lfsr_cur[k]),
      .nxt  (lfsr_nxt[k])
    );
  end

  // stimulus candidates for the next window
  always_comb begin
    rnd_cur = '0;
    rnd_nxt = '0;
    dir_v   = '0;
    for (int k = 0; k < LANES; k++) begin
      rnd_cur[k] = rep32(lfsr_cur[k]);
      rnd_nxt[k] = rep32(lfsr_nxt[k]);
      dir_v[k]   = rep32(DIRECTED);
    end
  end

  // failing-lane count, lowest failing lane, saturated mismatch total
  always_comb begin
    fail_n   = '0;
    low_lane = '0;
    any_fail = 1'b0;
    low_gold = '0;
    low_net  = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (fail[k]) begin
        fail_n   = fail_n + 7'd1;
        any_fail = 1'b1;
        low_lane = 6'(k);
        low_gold = gold_v[k];
        low_net  = net_v[k];
      end
    end
    mm_sum = SW'(mm_q) + SW'(fail_n);
    mm_nxt = (mm_sum > SW'({CNT_W{1'b1}})) ? '1 : mm_sum[CNT_W-1:0];
  end

  // previous start for edge qualification
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_q <= 1'b0;
    else      start_q <= bus.start;
  end

  // sequencer: phase walk with registered dut_rst/stim/busy/done/pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cyc       <= '0;
      vec_idx   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      dut_rst_q <= 1'b0;
      stim_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          state     <= RST1;
          cyc       <= '0;
          vec_idx   <= '0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          dut_rst_q <= 1'b1;
          stim_q    <= '0;
        end
        RST1: if (last) begin
          state     <= GAP1;
          cyc       <= '0;
          vec_idx   <= vec_idx + 32'd1;
          dut_rst_q <= 1'b0;
        end else cyc <= cyc + 1'b1;
        GAP1: begin
          state  <= RUN;
          stim_q <= rnd_cur;
        end
        RUN: if (last) begin
          cyc     <= '0;
          vec_idx <= vec_idx + 32'd1;
          if (vec_idx == 32'(NUM_VECTORS)) begin
            state     <= RST2;
            dut_rst_q <= 1'b1;
            stim_q    <= '0;
          end else begin
            stim_q <= rnd_nxt;
          end
        end else cyc <= cyc + 1'b1;
        RST2: if (last) begin
          state     <= GAP2;
          cyc       <= '0;
          vec_idx   <= vec_idx + 32'd1;
          dut_rst_q <= 1'b0;
        end else cyc <= cyc + 1'b1;
        GAP2: begin
          state  <= DIR;
          stim_q <= dir_v;
        end
        DIR: if (last) begin
          state  <= DONE;
          cyc    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (mm_nxt == '0);
          stim_q <= '0;
        end else cyc <= cyc + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // compare bookkeeping; capture only while no failure has been counted yet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mm_q  <= '0;
      vc_q  <= '0;
      ffv_q <= '0;
      ffl_q <= '0;
      fg_q  <= '0;
      fn_q  <= '0;
    end else if (go) begin
      mm_q  <= '0;
      vc_q  <= '0;
      ffv_q <= '0;
      ffl_q <= '0;
      fg_q  <= '0;
      fn_q  <= '0;
    end else if (cmp) begin
      vc_q <= vc_q + 1'b1;
      mm_q <= mm_nxt;
      if (any_fail && mm_q == '0) begin
        ffl_q <= low_lane;
        ffv_q <= CNT_W'(vec_idx);
        fg_q  <= low_gold;
        fn_q  <= low_net;
      end
    end
  end

  assign bus.dut_rst         = dut_rst_q;
  assign bus.stim            = stim_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.mismatch_cnt    = mm_q;
  assign bus.vec_cnt         = vc_q;
  assign bus.first_fail_lane = ffl_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_gold      = fg_q;
  assign bus.first_net       = fn_q;
endmodule

// File: doc/cosim_lockstep_checker.md
# cosim_lockstep_checker

Synthesizable lockstep checker for golden-versus-netlist co-simulation and on-board equivalence runs.
- Drives a shared stimulus and a shared active-high DUT reset into a golden model and a post-synthesis netlist across LANES independent channels.
- Compares the two outputs after a programmable settle window, counts mismatches and captures the first failure.
- Runs the fixed sequence: reset check, NUM_VECTORS pseudo-random vectors, second reset check, directed vector.
- Sits between the stimulus/reset pins of both DUT instances and a status register or LED.

## Interface
- WIDTH, 32: data width per lane.
- LANES, 1: number of independent channels (1..64).
- NUM_VECTORS, 1000: random vectors per run (≥1).
- SETTLE, 2: cycles each vector is held before compare (≥1).
- SEED, 32'h0000_0001: LFSR seed. Lane k seeds with SEED+k; a resulting zero seed is replaced by 32'h1.
- DIRECTED, 32'habcdefab: directed-phase pattern.
- CNT_W, 16: width of the mismatch and vector counters.

Ports (clock and reset first):
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  starts a run; sampled only in IDLE and DONE.
- dut_rst  out  1  active-high reset to both DUTs.
- stim  out  LANES*WIDTH  stimulus; lane k occupies bits [k*WIDTH +: WIDTH].
- gold_out  in  LANES*WIDTH  golden outputs.
- net_out  in  LANES*WIDTH  netlist outputs.
- busy  out  1  run in progress.
- done  out  1  run finished; held high until restart or reset.
- pass  out  1  equals done && mismatch_cnt==0.
- mismatch_cnt  out  CNT_W  saturating count of failing lane-compares.
- vec_cnt  out  CNT_W  compares performed.
- first_fail_lane  out  6  lane of the first failure.
- first_fail_vec  out  CNT_W  vector index of the first failure.
- first_gold, first_net  out  WIDTH each  captured values at the first failure.

## Operation
- Reset: all outputs 0 and state IDLE. dut_rst and stim are 0 while rst is low.
- **States:** IDLE → RST1 → GAP1 → RUN → RST2 → GAP2 → DIR → DONE.
  - start in IDLE or DONE → RST1. A start from DONE first clears all counters and captures and reloads the LFSRs.
- **RST1 / RST2:** dut_rst=1, stim=0, held SETTLE cycles, then one compare.
- **GAP1 / GAP2:** one cycle with dut_rst=0 and stim=0. No compare.
- **RUN:** each lane's stim is its LFSR state.
  - LFSR: 32-bit Galois, taps 32'h8020_0003.
  - The LFSR value is replicated and truncated to WIDTH.
  - The LFSR advances once per vector, at the end of the vector's window.
  - Each vector is held SETTLE cycles, then compared. NUM_VECTORS vectors in total.
- **DIR:** stim is DIRECTED (replicated and truncated) on every lane, held SETTLE cycles, then compared. Next state DONE.
- **Vector index:** RST1 = 0, random vectors 1..NUM_VECTORS, RST2 = NUM_VECTORS+1, DIR = NUM_VECTORS+2.
- **Compare:** on the last cycle of each window, lane k fails if gold_out[k] != net_out[k].
  - vec_cnt increments by 1 per compare.
  - mismatch_cnt increases by the number of failing lanes and saturates at all-ones.
- **First-failure capture:** on the first compare with any failure, capture the lowest failing lane, the vector index, and that lane's gold and net values. Later failures never overwrite the capture.
- start while busy is ignored.
- rst low mid-run aborts immediately and returns everything to reset values. No resume.

## Timing
- start sampled high at edge 0:
  - busy=1 and state RST1 from edge 1.
  - The compare of a window uses inputs sampled at the window's final edge.
  - The DUTs may have up to SETTLE-1 cycles of latency.
- Busy duration is (NUM_VECTORS+3)*SETTLE + 2 cycles.
- done=1 and busy=0 on the edge that completes DIR. pass is valid in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Loopback (gold=net=stim), LANES=2, NUM_VECTORS=8, SETTLE=2:
  - done 24 cycles after busy rises.
  - pass=1, mismatch_cnt=0, vec_cnt=11.
  - The lane 0 first random stim equals 32'h0000_0001.
- Flip bit 0 of net lane 1 during random vector 5 only:
  - mismatch_cnt=1, first_fail_lane=1, first_fail_vec=5, pass=0.
  - first_gold XOR first_net = 1.
- net tied to ~gold on all lanes, LANES=4, CNT_W=4:
  - mismatch_cnt saturates at 15.
  - first_fail_vec=0, first_fail_lane=0.
- Drop rst low during RUN vector 3:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release and start, the RUN stim sequence repeats from the seed value.
- Check the directed phase and the gaps:
  - During DIR: stim=32'habcdefab on every lane and dut_rst=0.
  - During each GAP: dut_rst=0 and stim=0 for exactly 1 cycle.
- Hold start high for the whole run:
  - The run executes once.
  - start pulsed in DONE restarts the run with vec_cnt cleared.
